// File: rtl/tck7_udp_beacon_pkg.sv
// Shared constants, header offsets and state encoding for the UDP beacon receiver.
package tck7_udp_beacon_pkg;

   localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;
   localparam logic [7:0]  IP_PROTO_UDP    = 8'd17;
   localparam logic [7:0]  IP_VER_IHL      = 8'h45;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hC704_DD7B;
   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
   localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
   localparam logic [7:0]  SFD_BYTE        = 8'hD5;
   localparam logic [2:0]  MAX_PREAMBLE    = 3'd7;
   localparam logic [10:0] MIN_FRAME_LEN   = 11'd64;
   localparam logic [15:0] MIN_UDP_LEN     = 16'd12;

   // Offsets of the last byte of each checked or captured header field.
   localparam logic [10:0] OFF_DST_MAC_LAST = 11'd5;
   localparam logic [10:0] OFF_SRC_MAC_LAST = 11'd11;
   localparam logic [10:0] OFF_ETYPE_LO     = 11'd13;
   localparam logic [10:0] OFF_VER_IHL      = 11'd14;
   localparam logic [10:0] OFF_PROTO        = 11'd23;
   localparam logic [10:0] OFF_SRC_IP_LAST  = 11'd29;
   localparam logic [10:0] OFF_UDP_DPORT_LO = 11'd37;
   localparam logic [10:0] OFF_UDP_LEN_LO   = 11'd39;
   localparam logic [10:0] OFF_WORD_LAST    = 11'd45;

   typedef enum logic [2:0] {IDLE, PREAMBLE, FRAME, END, DROP} rx_state_t;

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

endpackage

// File: rtl/tck7_crc32_byte.sv
// Combinational one-byte step of the reflected CRC-32; the state register lives in the caller.
module tck7_crc32_byte
   import tck7_udp_beacon_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);
   always_comb begin
      logic [31:0] c;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
      crc_out = c;
   end
endmodule

// File: rtl/tck7_udp_beacon_rx.sv
// GMII receive path for the UDP beacon: delineates and CRC-checks frames, filters beacons,
// presents the sender fields as a one-cycle strobe and keeps saturating status counters.
module tck7_udp_beacon_rx
   import tck7_udp_beacon_pkg::*;
#(
   parameter logic [15:0] UDP_PORT      = 16'd7777,
   parameter logic [47:0] LOCAL_MAC     = 48'h02_00_00_00_00_01,
   parameter int          MAX_FRAME_LEN = 1522
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   input  logic [7:0]  gmii_rxd,
   output logic        beacon_valid,
   output logic [47:0] beacon_src_mac,
   output logic [31:0] beacon_src_ip,
   output logic [15:0] beacon_payload_len,
   output logic [31:0] beacon_word,
   output logic [15:0] cnt_ok,
   output logic [15:0] cnt_crc_err,
   output logic [15:0] cnt_drop
);
   localparam logic [10:0] MAX_IDX = 11'(MAX_FRAME_LEN);

   rx_state_t   state, state_nxt;
   logic [2:0]  pre_cnt, pre_cnt_nxt;
   logic        armed;
   logic        sof, take, hdr_fail, inc_ok, inc_crc, inc_drop;
   logic [10:0] idx;
   logic [31:0] crc, crc_nxt;
   logic        reject;
   logic [39:0] shreg;
   logic [47:0] win;
   logic [47:0] cap_src_mac;
   logic [31:0] cap_src_ip, cap_word;
   logic [15:0] cap_udp_len;

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
      return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
   endfunction

   // Window of the last six frame bytes, current byte in the low octet.
   assign win = {shreg, gmii_rxd};

   tck7_crc32_byte u_crc (
      .crc_in  (crc),
      .data    (gmii_rxd),
      .crc_out (crc_nxt)
   );

   always_comb begin
      hdr_fail = 1'b0;
      case (idx)
         OFF_DST_MAC_LAST: hdr_fail = (win != 48'hFFFF_FFFF_FFFF) && (win != LOCAL_MAC);
         OFF_ETYPE_LO:     hdr_fail = win[15:0] != ETH_TYPE_IPV4;
         OFF_VER_IHL:      hdr_fail = gmii_rxd != IP_VER_IHL;
         OFF_PROTO:        hdr_fail = gmii_rxd != IP_PROTO_UDP;
         OFF_UDP_DPORT_LO: hdr_fail = win[15:0] != UDP_PORT;
         OFF_UDP_LEN_LO:   hdr_fail = win[15:0] < MIN_UDP_LEN;
         default:          hdr_fail = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt   = state;
      pre_cnt_nxt = pre_cnt;
      sof         = 1'b0;
      take        = 1'b0;
      inc_ok      = 1'b0;
      inc_crc     = 1'b0;
      inc_drop    = 1'b0;
      unique case (state)
         // END doubles as IDLE so a frame may start right after the evaluation cycle.
         IDLE, END: begin
            if (gmii_rx_dv) begin
               if (armed && gmii_rxd == PREAMBLE_BYTE) begin
                  state_nxt   = PREAMBLE;
                  pre_cnt_nxt = 3'd1;
               end else begin
                  state_nxt = DROP;
               end
            end
         end
         PREAMBLE: begin
            if (!gmii_rx_dv || gmii_rx_er) begin
               inc_drop  = 1'b1;
               state_nxt = DROP;
            end else if (gmii_rxd == SFD_BYTE) begin
               sof       = 1'b1;
               state_nxt = FRAME;
            end else if (gmii_rxd == PREAMBLE_BYTE && pre_cnt != MAX_PREAMBLE) begin
               pre_cnt_nxt = pre_cnt + 3'd1;
            end else begin
               inc_drop  = (gmii_rxd == PREAMBLE_BYTE);
               state_nxt = DROP;
            end
         end
         FRAME: begin
            if (!gmii_rx_dv) begin
               state_nxt = END;
               // The register is reflected, the residue constant is in normal bit order.
               if (bitrev32(crc) != CRC32_RESIDUE)     inc_crc  = 1'b1;
               else if (idx < MIN_FRAME_LEN || reject) inc_drop = 1'b1;
               else                                    inc_ok   = 1'b1;
            end else if (gmii_rx_er || idx == MAX_IDX) begin
               inc_drop  = 1'b1;
               state_nxt = DROP;
            end else begin
               take = 1'b1;
            end
         end
         DROP:    if (!gmii_rx_dv) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         pre_cnt <= '0;
         armed   <= 1'b0;
      end else begin
         state   <= state_nxt;
         pre_cnt <= pre_cnt_nxt;
         armed   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (sof) begin
         idx    <= '0;
         crc    <= '1;
         reject <= 1'b0;
      end else if (take) begin
         idx    <= idx + 11'd1;
         crc    <= crc_nxt;
         reject <= reject | hdr_fail;
         shreg  <= win[39:0];
         case (idx)
            OFF_SRC_MAC_LAST: cap_src_mac <= win;
            OFF_SRC_IP_LAST:  cap_src_ip  <= win[31:0];
            OFF_UDP_LEN_LO:   cap_udp_len <= win[15:0];
            OFF_WORD_LAST:    cap_word    <= win[31:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beacon_valid       <= 1'b0;
         beacon_src_mac     <= '0;
         beacon_src_ip      <= '0;
         beacon_payload_len <= '0;
         beacon_word        <= '0;
         cnt_ok             <= '0;
         cnt_crc_err        <= '0;
         cnt_drop           <= '0;
      end else begin
         beacon_valid <= inc_ok;
         if (inc_ok) begin
            beacon_src_mac     <= cap_src_mac;
            beacon_src_ip      <= cap_src_ip;
            beacon_payload_len <= cap_udp_len - 16'd8;
            beacon_word        <= cap_word;
         end
         cnt_ok      <= sat_inc(cnt_ok, inc_ok);
         cnt_crc_err <= sat_inc(cnt_crc_err, inc_crc);
         cnt_drop    <= sat_inc(cnt_drop, inc_drop);
      end
   end

endmodule

// File: tb/tb_tck7_udp_beacon_rx.sv
// Directed bench for tck7_udp_beacon_rx: builds GMII frames with a locally computed FCS.
module tb_tck7_udp_beacon_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic        gmii_rx_dv, gmii_rx_er;
   logic [7:0]  gmii_rxd;
   logic        beacon_valid;
   logic [47:0] beacon_src_mac;
   logic [31:0] beacon_src_ip;
   logic [15:0] beacon_payload_len;
   logic [31:0] beacon_word;
   logic [15:0] cnt_ok, cnt_crc_err, cnt_drop;

   localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] SRC_MAC = 48'h02_11_22_33_44_55;
   localparam logic [31:0] SRC_IP  = 32'hC0A8_0132;

   int n_cmp = 0;
   int n_bad = 0;
   int pulses, step, pulse_step, drop_step;
   logic last_dv;
   logic [7:0] fb[$];

   tck7_udp_beacon_rx dut (
      .clk                (clk),
      .reset              (reset),
      .gmii_rx_dv         (gmii_rx_dv),
      .gmii_rx_er         (gmii_rx_er),
      .gmii_rxd           (gmii_rxd),
      .beacon_valid       (beacon_valid),
      .beacon_src_mac     (beacon_src_mac),
      .beacon_src_ip      (beacon_src_ip),
      .beacon_payload_len (beacon_payload_len),
      .beacon_word        (beacon_word),
      .cnt_ok             (cnt_ok),
      .cnt_crc_err        (cnt_crc_err),
      .cnt_drop           (cnt_drop)
   );

   always #4 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic dv, input logic er, input logic [7:0] d);
      @(negedge clk);
      if (beacon_valid === 1'b1) begin
         pulses++;
         pulse_step = step;
      end
      gmii_rx_dv = dv;
      gmii_rx_er = er;
      gmii_rxd   = d;
      if (!dv && last_dv) drop_step = step;
      last_dv = dv;
      step++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic add_fcs();
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (fb[i]) begin
         c = c ^ {24'd0, fb[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) fb.push_back(c[8*k +: 8]);
   endtask

   task automatic build(input logic [47:0] dst, input logic [15:0] etype, input logic [7:0] proto,
                        input logic [15:0] dport, input logic [15:0] ulen, input logic [31:0] word,
                        input int nbytes);
      logic [47:0] src;
      logic [31:0] sip;
      logic [15:0] tot;
      src = SRC_MAC;
      sip = SRC_IP;
      tot = ulen + 16'd20;
      fb.delete();
      for (int i = 0; i < nbytes; i++) fb.push_back(8'(i * 7 + 3));
      for (int i = 0; i < 6; i++) begin
         fb[i]     = dst[47-8*i -: 8];
         fb[6 + i] = src[47-8*i -: 8];
      end
      fb[12] = etype[15:8]; fb[13] = etype[7:0];
      fb[14] = 8'h45;       fb[15] = 8'h00;
      fb[16] = tot[15:8];   fb[17] = tot[7:0];
      fb[22] = 8'd64;       fb[23] = proto;
      for (int i = 0; i < 4; i++) begin
         fb[26 + i] = sip[31-8*i -: 8];
         fb[42 + i] = word[31-8*i -: 8];
      end
      fb[34] = 8'h1E;       fb[35] = 8'h61;
      fb[36] = dport[15:8]; fb[37] = dport[7:0];
      fb[38] = ulen[15:8];  fb[39] = ulen[7:0];
      fb[40] = 8'h00;       fb[41] = 8'h00;
      add_fcs();
   endtask

   task automatic send(input int n_pre, input int er_at);
      for (int i = 0; i < n_pre; i++) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      foreach (fb[i]) drive(1'b1, 1'(i == er_at), fb[i]);
   endtask

   task automatic good_frame();
      build(BCAST, 16'h0800, 8'd17, 16'd7777, 16'd148, 32'hDEAD_BEEF, 182);
   endtask

   initial begin
      reset = 1'b1; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
      step = 0; pulses = 0; pulse_step = 0; drop_step = 0; last_dv = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      idle(2);
      chk("rst_valid", 64'(beacon_valid), 64'd0);
      chk("rst_mac", 64'(beacon_src_mac), 64'd0);
      chk("rst_ip", 64'(beacon_src_ip), 64'd0);
      chk("rst_len", 64'(beacon_payload_len), 64'd0);
      chk("rst_word", 64'(beacon_word), 64'd0);
      chk("rst_cnts", 64'({cnt_ok, cnt_crc_err, cnt_drop}), 64'd0);

      // Reference beacon
      good_frame(); pulses = 0;
      send(7, -1); idle(4);
      chk("good_pulses", 64'(pulses), 64'd1);
      chk("good_latency", 64'(pulse_step - drop_step), 64'd1);
      chk("good_len", 64'(beacon_payload_len), 64'd140);
      chk("good_word", 64'(beacon_word), 64'hDEAD_BEEF);
      chk("good_mac", 64'(beacon_src_mac), 64'(SRC_MAC));
      chk("good_ip", 64'(beacon_src_ip), 64'(SRC_IP));
      chk("good_cnts", 64'({cnt_ok, cnt_crc_err, cnt_drop}), {16'd0, 16'd1, 16'd0, 16'd0});

      // Corrupted payload bit
      good_frame(); fb[100] = fb[100] ^ 8'h01; pulses = 0;
      send(7, -1); idle(4);
      chk("crc_pulses", 64'(pulses), 64'd0);
      chk("crc_cnts", 64'({cnt_ok, cnt_crc_err, cnt_drop}), {16'd0, 16'd1, 16'd1, 16'd0});

      // Header filter rejects, each with a valid FCS
      pulses = 0;
      build(BCAST, 16'h86DD, 8'd17, 16'd7777, 16'd148, 32'h1234_5678, 182); send(7, -1); idle(4);
      build(BCAST, 16'h0800, 8'd6, 16'd7777, 16'd148, 32'h1234_5678, 182);  send(7, -1); idle(4);
      build(BCAST, 16'h0800, 8'd17, 16'd7778, 16'd148, 32'h1234_5678, 182); send(7, -1); idle(4);
      build(48'h02_00_00_00_00_02, 16'h0800, 8'd17, 16'd7777, 16'd148, 32'h1234_5678, 182);
      send(7, -1); idle(4);
      chk("rej_pulses", 64'(pulses), 64'd0);
      chk("rej_drop", 64'(cnt_drop), 64'd4);
      chk("rej_word_held", 64'(beacon_word), 64'hDEAD_BEEF);

      // 60-byte runt, then UDP length just below minimum
      build(BCAST, 16'h0800, 8'd17, 16'd7777, 16'd12, 32'h1234_5678, 56); send(7, -1); idle(4);
      chk("runt_drop", 64'(cnt_drop), 64'd5);
      build(BCAST, 16'h0800, 8'd17, 16'd7777, 16'd11, 32'h1234_5678, 60); send(7, -1); idle(4);
      chk("ulen_drop", 64'(cnt_drop), 64'd6);
      chk("short_pulses", 64'(pulses), 64'd0);

      // Minimum-size accepted frame to LOCAL_MAC
      build(48'h02_00_00_00_00_01, 16'h0800, 8'd17, 16'd7777, 16'd12, 32'hCAFE_F00D, 60);
      pulses = 0; send(7, -1); idle(4);
      chk("min_pulses", 64'(pulses), 64'd1);
      chk("min_latency", 64'(pulse_step - drop_step), 64'd1);
      chk("min_len", 64'(beacon_payload_len), 64'd4);
      chk("min_word", 64'(beacon_word), 64'hCAFE_F00D);
      chk("min_ok", 64'(cnt_ok), 64'd2);

      // rx_er mid-frame, then two good frames each after a 1-cycle gap
      good_frame(); pulses = 0;
      send(7, 50); idle(1);
      send(7, -1); idle(1);
      send(7, -1); idle(4);
      chk("er_pulses", 64'(pulses), 64'd2);
      chk("er_cnts", 64'({cnt_ok, cnt_crc_err, cnt_drop}), {16'd0, 16'd4, 16'd1, 16'd7});
      chk("er_word", 64'(beacon_word), 64'hDEAD_BEEF);

      // Preamble too long, then shortest legal preamble
      pulses = 0; send(8, -1); idle(4);
      chk("pre8_pulses", 64'(pulses), 64'd0);
      chk("pre8_drop", 64'(cnt_drop), 64'd8);
      send(1, -1); idle(4);
      chk("pre1_pulses", 64'(pulses), 64'd1);
      chk("pre1_ok", 64'(cnt_ok), 64'd5);

      // Reset mid-frame, released while dv is still high
      pulses = 0;
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, fb[i]);
      reset = 1'b1;
      for (int i = 30; i < 33; i++) drive(1'b1, 1'b0, fb[i]);
      chk("mid_rst_cnts", 64'({cnt_ok, cnt_crc_err, cnt_drop}), 64'd0);
      chk("mid_rst_word", 64'(beacon_word), 64'd0);
      reset = 1'b0;
      send(7, -1); idle(4);
      chk("post_rst_pulses", 64'(pulses), 64'd0);
      chk("post_rst_cnts", 64'({cnt_ok, cnt_crc_err, cnt_drop}), 64'd0);
      send(7, -1); idle(4);
      chk("next_pulses", 64'(pulses), 64'd1);
      chk("next_ok", 64'(cnt_ok), 64'd1);
      chk("next_mac", 64'(beacon_src_mac), 64'(SRC_MAC));

      // Saturation of cnt_ok
      @(negedge clk);
      force dut.cnt_ok = 16'hFFFE;
      @(negedge clk);
      release dut.cnt_ok;
      @(negedge clk);
      chk("sat_preset", 64'(cnt_ok), 64'hFFFE);
      pulses = 0;
      send(7, -1); idle(4);
      chk("sat_reach", 64'(cnt_ok), 64'hFFFF);
      send(7, -1); idle(4);
      chk("sat_hold", 64'(cnt_ok), 64'hFFFF);
      chk("sat_pulses", 64'(pulses), 64'd2);
      chk("sat_others", 64'({cnt_crc_err, cnt_drop}), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
